// File: rtl/mux_n_pipe_pkg.sv
// ============================================================================
// mux_n_pipe_pkg : shared constants, stage control record, counter helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_n_pipe_pkg;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] c_ERR_CNT_MAX = '1;

  // Control half of the {valid, err, data} stage record; the WIDTH-wide data
  // half is declared beside it in the stage because package types cannot
  // take a module parameter.
  typedef struct packed {
    logic valid;
    logic err;
  } stage_ctrl_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == c_ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_pipe_stage.sv
// ============================================================================
// mux_pipe_stage : one {valid, err, data} register with rst > flush > stall
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_pipe_stage
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  stage_ctrl_t      ctrl_i,
  input  logic [WIDTH-1:0] data_i,
  output stage_ctrl_t      ctrl_o,
  output logic [WIDTH-1:0] data_o
);

  stage_ctrl_t      ctrl_q, ctrl_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush drops valid/err only; data is left stale since nobody qualifies it.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush_i) begin
      ctrl_d = '0;
    end else if (!stall_i) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/mux_n_pipe.sv
// ============================================================================
// mux_n_pipe : N-to-1 selector feeding a DEPTH-stage stall/flush pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter  int NUM_IN = 3,
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 1,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  output logic                    sel_err_o,
  output logic [ERR_CNT_W-1:0]    err_cnt_o
);

  logic [WIDTH-1:0]     pick_data;
  logic                 sel_oor;
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Index 0 is the combinational pick; index s is the output of stage s.
  stage_ctrl_t          ctrl_s [DEPTH+1];
  logic [WIDTH-1:0]     data_s [DEPTH+1];

  assign sel_oor = (32'(select_i) >= NUM_IN);
  assign accept  = valid_i & ~stall_i & ~flush_i;

  // Any unmatched select falls through to the all-zero default.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        pick_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // A bubble never carries an error flag.
  assign ctrl_s[0] = '{valid: valid_i, err: valid_i & sel_oor};
  assign data_s[0] = pick_data;

  for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
    mux_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .stall_i(stall_i),
      .flush_i(flush_i),
      .ctrl_i (ctrl_s[s-1]),
      .data_i (data_s[s-1]),
      .ctrl_o (ctrl_s[s]),
      .data_o (data_s[s])
    );
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel_oor) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data_o    = data_s[DEPTH];
  assign valid_o   = ctrl_s[DEPTH].valid;
  assign sel_err_o = ctrl_s[DEPTH].err;
  assign err_cnt_o = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
// ============================================================================
// tb_mux_n_pipe : directed checks on 3x32 (DEPTH 2 and 3) and 16x8 (DEPTH 1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] data3;
  logic [1:0]  sel3;
  logic        valid3, stall, flush;

  logic [31:0] d2_data, d3_data;
  logic        d2_valid, d2_err, d3_valid, d3_err;
  logic [7:0]  d2_cnt, d3_cnt;

  logic [127:0] data16;
  logic [3:0]   sel16;
  logic         valid16;
  logic [7:0]   e_data, e_cnt;
  logic         e_valid, e_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.NUM_IN(3), .WIDTH(32), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .data_i(data3), .select_i(sel3), .valid_i(valid3),
    .stall_i(stall), .flush_i(flush), .data_o(d2_data), .valid_o(d2_valid),
    .sel_err_o(d2_err), .err_cnt_o(d2_cnt)
  );

  mux_n_pipe #(.NUM_IN(3), .WIDTH(32), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .data_i(data3), .select_i(sel3), .valid_i(valid3),
    .stall_i(stall), .flush_i(flush), .data_o(d3_data), .valid_o(d3_valid),
    .sel_err_o(d3_err), .err_cnt_o(d3_cnt)
  );

  mux_n_pipe #(.NUM_IN(16), .WIDTH(8), .DEPTH(1)) u_e (
    .clk_i(clk), .rst_i(rst), .data_i(data16), .select_i(sel16), .valid_i(valid16),
    .stall_i(stall), .flush_i(flush), .data_o(e_data), .valid_o(e_valid),
    .sel_err_o(e_err), .err_cnt_o(e_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    valid3 = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    sel3   = 2'd0;
    data3  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 16; k++) data16[k*8 +: 8] = 8'(k);
    data16[15*8 +: 8] = 8'hA5;
    sel16   = 4'd0;
    valid16 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_data",  d2_data, 32'h0);
    check("rst_valid", 32'(d2_valid), 32'h0);
    check("rst_err",   32'(d2_err), 32'h0);
    check("rst_cnt",   32'(d2_cnt), 32'h0);
    check("rst_e_valid", 32'(e_valid), 32'h0);
    rst = 1'b0;

    // 16x8 corner, DEPTH 1
    sel16 = 4'd15; valid16 = 1'b1; tick();
    check("e_sel15_data",  32'(e_data), 32'hA5);
    check("e_sel15_valid", 32'(e_valid), 32'h1);
    sel16 = 4'd3; tick();
    check("e_sel3_data", 32'(e_data), 32'h03);
    sel16 = 4'd15; valid16 = 1'b0; tick();
    check("e_bubble_valid", 32'(e_valid), 32'h0);
    check("e_bubble_err",   32'(e_err), 32'h0);
    check("e_bubble_cnt",   32'(e_cnt), 32'h0);

    // Select sweep, DEPTH 2
    valid3 = 1'b1; sel3 = 2'd0; tick();
    check("sweep_lat_valid", 32'(d2_valid), 32'h0);
    sel3 = 2'd1; tick();
    check("sweep0_data",  d2_data, 32'h1111_1111);
    check("sweep0_valid", 32'(d2_valid), 32'h1);
    sel3 = 2'd2; tick();
    check("sweep1_data", d2_data, 32'h2222_2222);
    valid3 = 1'b0; tick();
    check("sweep2_data",  d2_data, 32'h3333_3333);
    check("sweep2_valid", 32'(d2_valid), 32'h1);
    tick();
    check("sweep_end_valid", 32'(d2_valid), 32'h0);
    check("sweep_cnt", 32'(d2_cnt), 32'h0);

    // Out-of-range select
    valid3 = 1'b1; sel3 = 2'd3; tick();
    check("oor_cnt_early", 32'(d2_cnt), 32'h1);
    valid3 = 1'b0; tick();
    check("oor_data",  d2_data, 32'h0);
    check("oor_err",   32'(d2_err), 32'h1);
    check("oor_valid", 32'(d2_valid), 32'h1);
    tick();
    check("oor_err_clear", 32'(d2_err), 32'h0);
    tick();
    tick();

    // Stall hold, DEPTH 3; stalled input would be an out-of-range beat
    valid3 = 1'b1; sel3 = 2'd0; tick();
    sel3 = 2'd1; tick();
    check("stall_pre_valid", 32'(d3_valid), 32'h0);
    sel3 = 2'd2; tick();
    check("stall_pre_data", d3_data, 32'h1111_1111);
    stall = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold_data",  d3_data, 32'h1111_1111);
      check("stall_hold_valid", 32'(d3_valid), 32'h1);
    end
    check("stall_cnt", 32'(d3_cnt), 32'h1);
    stall = 1'b0; valid3 = 1'b0; tick();
    check("stall_b1_data", d3_data, 32'h2222_2222);
    tick();
    check("stall_b2_data",  d3_data, 32'h3333_3333);
    check("stall_b2_valid", 32'(d3_valid), 32'h1);
    tick();
    check("stall_no_dup", 32'(d3_valid), 32'h0);

    // Flush beats stall
    valid3 = 1'b1;
    sel3 = 2'd0; tick();
    sel3 = 2'd1; tick();
    sel3 = 2'd2; tick();
    check("flush_full", 32'(d2_valid), 32'h1);
    stall = 1'b1; flush = 1'b1; sel3 = 2'd3; tick();
    check("flush_valid_d2", 32'(d2_valid), 32'h0);
    check("flush_valid_d3", 32'(d3_valid), 32'h0);
    check("flush_cnt",      32'(d2_cnt), 32'h1);
    stall = 1'b0; flush = 1'b0; valid3 = 1'b0; tick();
    check("flush_after1", 32'(d2_valid), 32'h0);
    tick();
    check("flush_after2", 32'(d2_valid), 32'h0);
    valid3 = 1'b1; sel3 = 2'd1; tick();
    valid3 = 1'b0; tick();
    check("flush_new_data",  d2_data, 32'h2222_2222);
    check("flush_new_valid", 32'(d2_valid), 32'h1);

    // Counter saturation: 300 out-of-range beats starting from 1
    valid3 = 1'b1; sel3 = 2'd3;
    repeat (253) tick();
    check("sat_254", 32'(d2_cnt), 32'd254);
    tick();
    check("sat_255", 32'(d2_cnt), 32'd255);
    repeat (46) tick();
    check("sat_hold", 32'(d2_cnt), 32'd255);
    rst = 1'b1; tick();
    check("sat_rst_cnt",   32'(d2_cnt), 32'h0);
    check("sat_rst_valid", 32'(d2_valid), 32'h0);
    check("sat_rst_data",  d2_data, 32'h0);
    rst = 1'b0;

    // Reset mid-stream discards in-flight beats
    sel3 = 2'd0; tick();
    sel3 = 2'd1; tick();
    check("mid_pre_valid", 32'(d2_valid), 32'h1);
    rst = 1'b1; tick();
    check("mid_rst_valid", 32'(d2_valid), 32'h0);
    rst = 1'b0; valid3 = 1'b0; tick();
    check("mid_after_valid", 32'(d2_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
